// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS phase accumulator.
//   CFG_SEL_*  : meaning of cfg_sel on a configuration write
//   dds_state_e: sweep sequencer states
//   LFSR_SEED / LFSR_TAPS: 16-bit Fibonacci dither generator (taps 16,14,13,11)
package dds_pkg;

  localparam logic CFG_SEL_TUNE   = 1'b0;
  localparam logic CFG_SEL_OFFSET = 1'b1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} dds_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bit positions 15,13,12,10 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dds_lfsr.sv
// 16-bit Fibonacci LFSR used as output dither source.
// Ports:
//   clk    : clock
//   rst_n  : async active-low reset, loads LFSR_SEED
//   en_i   : advance one step this cycle
//   lfsr_o : current register value
module dds_lfsr
  import dds_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr_q <= LFSR_SEED;
    else if (en_i) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/multi_phase_accumulator.sv
// Time-multiplexed DDS phase accumulator for NUM_CH channels sharing one adder.
// Each ce in IDLE launches a sweep that updates channels 0..NUM_CH-1, one per
// clock, and emits a truncated, offset phase tagged with its channel.
// Optional: define MULTI_PHASE_ACCUMULATOR_DITHER_EN to add LFSR dither to the
// output path (stored phase unaffected).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   ce                  : start a sweep (ignored and flagged while sweeping)
//   sync_clr            : zero all phases (deferred to sweep end if sweeping)
//   cfg_valid/cfg_ready : config write handshake (ready only in IDLE)
//   cfg_ch/cfg_sel/cfg_data : target channel, tune(0)/offset(1), data
//   out_valid/out_ch/out_phase : registered per-channel phase output
//   overrun             : sticky, ce seen during a sweep
module multi_phase_accumulator
  import dds_pkg::*;
#(
  parameter int ACC_W  = 23,
  parameter int OUT_W  = 14,
  parameter int TUNE_W = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [TUNE_W-1:0] cfg_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [OUT_W-1:0]  out_phase,
  output logic              overrun
);

  dds_state_e        state_q;
  logic [CH_W-1:0]   idx_q;
  logic [ACC_W-1:0]  phase_q [NUM_CH];
  logic [TUNE_W-1:0] tune_q  [NUM_CH];
  logic [OUT_W-1:0]  off_q   [NUM_CH];
  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [OUT_W-1:0]  out_phase_q;
  logic              overrun_q;
  logic              clr_pend_q;

  logic [ACC_W-1:0]  sum;
  logic [OUT_W-1:0]  trunc;
  logic [OUT_W-1:0]  out_phase_d;
  logic              last_ch;
  logic              cfg_we;

  assign cfg_ready = (state_q == IDLE);
  assign cfg_we    = cfg_valid && cfg_ready && (int'(cfg_ch) < NUM_CH);
  assign last_ch   = (idx_q == CH_W'(NUM_CH - 1));

  // Shared adder: tuning word is zero-extended into the accumulator width.
  assign sum = phase_q[idx_q] + ACC_W'(tune_q[idx_q]);

`ifdef MULTI_PHASE_ACCUMULATOR_DITHER_EN
  localparam int DW = (ACC_W - OUT_W < 16) ? (ACC_W - OUT_W) : 16;
  logic [15:0]      lfsr;
  logic [ACC_W-1:0] dith;
  logic [ACC_W-1:0] dsum;

  dds_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == RUN),
    .lfsr_o (lfsr)
  );

  // Only the bits that would otherwise be truncated away receive dither.
  always_comb begin
    dith = '0;
    for (int i = 0; i < DW; i++) dith[i] = lfsr[i];
  end

  assign dsum  = sum + dith;
  assign trunc = dsum[ACC_W-1 -: OUT_W];
`else
  assign trunc = sum[ACC_W-1 -: OUT_W];
`endif

  assign out_phase_d = trunc + off_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_phase_q <= '0;
      overrun_q   <= 1'b0;
      clr_pend_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= '0;
        tune_q[i]  <= '0;
        off_q[i]   <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;

      if (cfg_we) begin
        if (cfg_sel == CFG_SEL_TUNE) tune_q[cfg_ch] <= cfg_data;
        else                         off_q[cfg_ch]  <= OUT_W'(cfg_data);
      end

      unique case (state_q)
        IDLE: begin
          if (sync_clr) begin
            for (int i = 0; i < NUM_CH; i++) phase_q[i] <= '0;
          end else if (ce) begin
            state_q <= RUN;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (ce) overrun_q <= 1'b1;
          out_valid_q     <= 1'b1;
          out_ch_q        <= idx_q;
          out_phase_q     <= out_phase_d;
          phase_q[idx_q]  <= sum;
          if (last_ch) begin
            state_q    <= IDLE;
            clr_pend_q <= 1'b0;
            // Deferred clear overrides the last channel's store.
            if (clr_pend_q || sync_clr) begin
              for (int i = 0; i < NUM_CH; i++) phase_q[i] <= '0;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
            if (sync_clr) clr_pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_phase = out_phase_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_multi_phase_accumulator.sv
module tb_multi_phase_accumulator;
  import dds_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        sync_clr = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic        cfg_sel = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [13:0] out_phase;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  multi_phase_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .sync_clr  (sync_clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_phase (out_phase),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic sel, input logic [15:0] data);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
  endtask

  // One full sweep from IDLE: ce for one cycle, then NUM_CH outputs, then idle.
  task automatic sweep(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    ce = 1'b1;
    tick();
    ce = 1'b0;
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_ch"},  32'(out_ch),    32'(k));
      chk({tag, "_ph"},  32'(out_phase), 32'(exp[k]));
    end
    tick();
    chk({tag, "_end"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_ch",  32'(out_ch),    32'd0);
    chk("rst_ph",  32'(out_phase), 32'd0);
    chk("rst_ovr", 32'(overrun),   32'd0);
    chk("rst_rdy", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic accumulation: 512 in a 23-bit acc is one LSB of the 14-bit output
    cfg_write(2'd0, CFG_SEL_TUNE, 16'd512);
    sweep("s1", 1, 0, 0, 0);
    sweep("s2", 2, 0, 0, 0);
    sweep("s3", 3, 0, 0, 0);

    // Tune 0 holds ch0; ch1 steps 64 per sweep and wraps at sweep 256
    cfg_write(2'd0, CFG_SEL_TUNE, 16'd0);
    cfg_write(2'd1, CFG_SEL_TUNE, 16'h8000);
    for (int s = 1; s <= 256; s++) sweep("wrap", 3, (64 * s) % 16384, 0, 0);

    // Offset wrap
    pulse_clr();
    cfg_write(2'd1, CFG_SEL_TUNE, 16'd0);
    cfg_write(2'd0, CFG_SEL_TUNE, 16'd512);
    cfg_write(2'd0, CFG_SEL_OFFSET, 16'h3FFF);
    sweep("off1", 0, 0, 0, 0);
    sweep("off2", 1, 0, 0, 0);
    cfg_write(2'd0, CFG_SEL_OFFSET, 16'h0000);

    // ce held for 3 cycles -> one sweep, overrun set; write during RUN dropped
    ce = 1'b1;
    tick();
    chk("ovr_rdy", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_sel = CFG_SEL_TUNE; cfg_data = 16'h1234;
    tick();
    chk("ovr_p0", 32'(out_phase), 32'd3);
    chk("ovr_v0", 32'(out_valid), 32'd1);
    tick();
    ce = 1'b0;
    cfg_valid = 1'b0;
    chk("ovr_c1", 32'(out_ch), 32'd1);
    tick();
    tick();
    chk("ovr_c3", 32'(out_ch), 32'd3);
    tick();
    chk("ovr_end", 32'(out_valid), 32'd0);
    chk("ovr_flag", 32'(overrun), 32'd1);
    tick();
    chk("ovr_one", 32'(out_valid), 32'd0);
    sweep("ovr_nw", 4, 0, 0, 0);
    chk("ovr_stk", 32'(overrun), 32'd1);

    // sync_clr during RUN deferred to sweep end
    for (int c = 0; c < 4; c++) cfg_write(2'(c), CFG_SEL_TUNE, 16'd512);
    pulse_clr();
    ce = 1'b1;
    tick();
    ce = 1'b0;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    chk("clr_p0", 32'(out_phase), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("clr_ch", 32'(out_ch),    32'(k));
      chk("clr_ph", 32'(out_phase), 32'd1);
    end
    tick();
    sweep("clr_nx", 1, 1, 1, 1);

    // Reset in the middle of a sweep
    ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
    chk("mr_pre", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_vld", 32'(out_valid), 32'd0);
    chk("mr_ph",  32'(out_phase), 32'd0);
    chk("mr_rdy", 32'(cfg_ready), 32'd1);
    chk("mr_ovr", 32'(overrun),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    cfg_write(2'd0, CFG_SEL_TUNE, 16'd512);
    sweep("mr_sw", 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
